// File: rtl/age_sort_pipe.sv
// Bitonic age sorter for the bufferless router: oldest valid flit to lane 0,
// empty lanes last, with optional registers after each compare stage.
module age_sort_pipe #(
  parameter int          NUM_PORTS = 4,
  parameter int          FLIT_W    = 64,
  parameter int          AGE_LSB   = 0,
  parameter int          AGE_W     = 8,
  parameter logic [31:0] PIPE_MASK = '1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]    in_flit,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
  output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] out_src
);

  localparam int L  = $clog2(NUM_PORTS);
  localparam int SW = (L < 1) ? 1 : L;
  localparam int S  = L * (L + 1) / 2;

  typedef struct packed {
    logic              valid;
    logic [FLIT_W-1:0] flit;
    logic [SW-1:0]     src;
  } lane_t;

  typedef logic [AGE_W+SW:0] key_t;

  // Inverted source index makes the key a total order: lower lane wins ties.
  function automatic key_t key(input lane_t x);
    return {x.valid, x.flit[AGE_LSB +: AGE_W], ~x.src};
  endfunction

  lane_t stg [S+1][NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_io
    assign stg[0][i] = '{
      valid: in_valid[i],
      flit:  in_flit[i*FLIT_W +: FLIT_W],
      src:   SW'(i)
    };
    assign out_valid[i]              = stg[S][i].valid;
    assign out_flit[i*FLIT_W +: FLIT_W] = stg[S][i].flit;
    assign out_src[i*SW +: SW]       = stg[S][i].src;
  end

  for (genvar lk = 1; lk <= L; lk++) begin : g_merge
    for (genvar lj = lk - 1; lj >= 0; lj--) begin : g_step
      localparam int ST = lk * (lk - 1) / 2 + (lk - 1 - lj);
      localparam int K  = 1 << lk;
      localparam int J  = 1 << lj;

      lane_t c [NUM_PORTS];

      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cs
        if ((i & J) == 0) begin : g_unit
          localparam int  PR = i | J;
          localparam bit  UP = (i & K) != 0;
          logic swap;
          assign swap = UP ?
            (key(stg[ST][i]) > key(stg[ST][PR])) :
            (key(stg[ST][i]) < key(stg[ST][PR]));
          assign c[i]  = swap ? stg[ST][PR] : stg[ST][i];
          assign c[PR] = swap ? stg[ST][i]  : stg[ST][PR];
        end
      end

      if (PIPE_MASK[ST]) begin : g_reg
        lane_t q [NUM_PORTS];
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) q[i] <= '0;
          end else if (en) begin
            for (int i = 0; i < NUM_PORTS; i++) q[i] <= c[i];
          end
        end
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_o
          assign stg[ST+1][i] = q[i];
        end
      end else begin : g_wire
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_o
          assign stg[ST+1][i] = c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_age_sort_pipe.sv
// Bench for age_sort_pipe: golden selection-sort model in a delay line,
// checked every cycle, plus hand-computed literal expectations.
module tb_age_sort_pipe;

  localparam int N  = 4;
  localparam int FW = 64;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int P  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*FW-1:0] in_flit = '0;
  logic [N-1:0]    out_valid;
  logic [N*FW-1:0] out_flit;
  logic [N*SW-1:0] out_src;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  age_sort_pipe #(
    .NUM_PORTS(N), .FLIT_W(FW), .AGE_LSB(0),
    .AGE_W(AW), .PIPE_MASK(32'h7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_flit(in_flit),
    .out_valid(out_valid), .out_flit(out_flit),
    .out_src(out_src)
  );

  // Golden: repeatedly pick the best remaining lane; strict compare keeps
  // the lowest index on ties, invalid lanes rank below every valid lane.
  function automatic void gsort(
    input  logic [N-1:0]    v,
    input  logic [N*FW-1:0] f,
    output logic [N-1:0]    ov,
    output logic [N*FW-1:0] of,
    output logic [N*SW-1:0] os
  );
    bit used [N];
    int b;
    for (int i = 0; i < N; i++) used[i] = 1'b0;
    ov = '0; of = '0; os = '0;
    for (int o = 0; o < N; o++) begin
      b = -1;
      for (int i = 0; i < N; i++) begin
        if (!used[i]) begin
          if (b < 0) b = i;
          else if ({v[i], f[i*FW +: AW]} > {v[b], f[b*FW +: AW]}) b = i;
        end
      end
      used[b] = 1'b1;
      ov[o] = v[b];
      of[o*FW +: FW] = f[b*FW +: FW];
      os[o*SW +: SW] = SW'(b);
    end
  endfunction

  logic [N-1:0]    mv [P];
  logic [N*FW-1:0] mf [P];
  logic [N*SW-1:0] ms [P];

  always @(posedge clk) begin
    logic [N-1:0]    v;
    logic [N*FW-1:0] f;
    logic [N*SW-1:0] s;
    if (!rst_n) begin
      for (int k = 0; k < P; k++) begin
        mv[k] = '0; mf[k] = '0; ms[k] = '0;
      end
    end else if (en) begin
      gsort(in_valid, in_flit, v, f, s);
      for (int k = P - 1; k > 0; k--) begin
        mv[k] = mv[k-1]; mf[k] = mf[k-1]; ms[k] = ms[k-1];
      end
      mv[0] = v; mf[0] = f; ms[0] = s;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (out_valid !== mv[P-1] || out_src !== ms[P-1] ||
          out_flit !== mf[P-1]) begin
        errors++;
        $display("FAIL model t=%0t valid=%b src=%h flit=%h required valid=%b src=%h flit=%h",
                 $time, out_valid, out_src, out_flit,
                 mv[P-1], ms[P-1], mf[P-1]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [7:0] age,
                                       input logic [55:0] tag);
    return {tag, age};
  endfunction

  function automatic logic [N*FW-1:0] rnd_set(input int max_age);
    logic [N*FW-1:0] f;
    for (int i = 0; i < N; i++)
      f[i*FW +: FW] = {$urandom, $urandom} & ~64'hFF
                      | 64'($urandom_range(0, max_age));
    return f;
  endfunction

  initial begin
    // reset with random traffic and en=1
    rst_n = 1'b0; en = 1'b1;
    in_valid = 4'($urandom); in_flit = rnd_set(255);
    step();
    chk_on = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_flit0", out_flit[63:0], 64'h0);
    in_valid = 4'($urandom); in_flit = rnd_set(255);
    step();
    chk("rst_src", 64'(out_src), 64'h0);
    rst_n = 1'b1;
    in_valid = 4'hF; in_flit = rnd_set(255);
    step();
    chk("post_rst1_valid", 64'(out_valid), 64'h0);
    in_valid = 4'h0;
    step();
    chk("post_rst2_valid", 64'(out_valid), 64'h0);
    chk("post_rst2_flit3", out_flit[255:192], 64'h0);
    step();

    // full sort, ages {5,200,17,99}
    in_valid = 4'hF;
    in_flit = {mk(8'd99, 56'h33), mk(8'd17, 56'h22),
               mk(8'd200, 56'h11), mk(8'd5, 56'h00)};
    step();
    in_valid = 4'h0;
    step();
    step();
    chk("sort_valid", 64'(out_valid), 64'hF);
    chk("sort_age0", 64'(out_flit[7:0]), 64'd200);
    chk("sort_age1", 64'(out_flit[71:64]), 64'd99);
    chk("sort_age2", 64'(out_flit[135:128]), 64'd17);
    chk("sort_age3", 64'(out_flit[199:192]), 64'd5);
    chk("sort_src", 64'(out_src), 64'h2D);
    chk("sort_flit0", out_flit[63:0], mk(8'd200, 56'h11));

    // ties and empty lanes
    in_valid = 4'b0101;
    in_flit = {mk(8'd60, 56'h3), mk(8'd7, 56'h2),
               mk(8'd50, 56'h1), mk(8'd7, 56'h0)};
    step();
    in_valid = 4'h0;
    step();
    step();
    chk("tie_valid", 64'(out_valid), 64'h3);
    chk("tie_src0", 64'(out_src[1:0]), 64'd0);
    chk("tie_src1", 64'(out_src[3:2]), 64'd2);
    chk("tie_src_all", 64'(out_src), 64'h78);

    // hold in mid-stream
    for (int n = 0; n < 4; n++) begin
      in_valid = 4'hF; in_flit = rnd_set(255);
      step();
      if (n == 1) begin
        en = 1'b0;
        in_flit = rnd_set(255);
        step();
        in_valid = 4'b1010;
        step();
        en = 1'b1;
      end
    end
    in_valid = 4'h0;
    repeat (4) step();

    // reset with three sets in flight
    for (int n = 0; n < 3; n++) begin
      in_valid = 4'hF; in_flit = rnd_set(255);
      step();
    end
    rst_n = 1'b0; in_valid = 4'h0;
    step();
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_flit0", out_flit[63:0], 64'h0);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("midrst_drain", 64'(out_valid), 64'h0);
    end

    // random traffic with ties and random stalls
    for (int n = 0; n < 400; n++) begin
      in_valid = 4'($urandom);
      in_flit = rnd_set((n % 2) ? 3 : 255);
      en = ($urandom_range(0, 4) != 0);
      step();
    end
    en = 1'b1; in_valid = 4'h0;
    repeat (4) step();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
